iir_inv: RTL

IIR_INV -- requirements
Module: iir_inv

---
 rtl/iir_inv.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/iir_inv.sv
// iir_inv -- all-pole inverse IIR filter, y[n] = x[n] - sum(k=1..ORDER) a_k*y[n-k].
//
// One sample at a time: IDLE accepts x[n], MAC runs one multiply-accumulate
// per tap, OUT presents y[n] until the consumer takes it.
//
// Optional feature: define IIR_INV_SAT_EN to saturate the output to the DW
// range. Without it the output is the plain two's-complement wrap of the
// accumulator.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   in_data    x[n], Q5.6 signed          in_valid / in_ready   input handshake
//   out_data   y[n], Q5.6 signed          out_valid / out_ready output handshake
//   coef_we    coefficient write strobe (IDLE only)
//   coef_addr  tap index k-1
//   coef_data  a_k, Q1.6 signed
//
// Timing: a sample accepted at edge t is presented after edge t+ORDER+1.

module iir_inv #(
  parameter int ORDER = 4,
  parameter int DW    = 12,
  parameter int CW    = 8,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          coef_we,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_data
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic [3:0] ORDER_L = 4'(ORDER);
  // tap counter runs 1..ORDER for the multiplies; ORDER+1 is the hand-off
  // cycle where the finished accumulator is converted into out_data
  localparam logic [3:0] TAP_END = 4'(ORDER + 1);

  state_t                 state, state_nxt;
  logic                   started;
  logic [3:0]             tap;
  logic [3:0]             tap_m1;
  logic [2:0]             tap_idx;
  logic signed [AW-1:0]   acc;
  logic signed [DW-1:0]   hist [0:7];
  logic signed [CW-1:0]   coef [0:7];
  logic [DW-1:0]          out_reg;
  logic signed [CW+DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   x_ext;
  logic [DW-1:0]          conv;
  logic                   accept;

  // in_ready stays low until the first edge after reset release
  assign in_ready  = started && (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = out_reg;
  assign accept    = in_valid && in_ready;

  assign tap_m1   = tap - 4'd1;
  assign tap_idx  = tap_m1[2:0];
  assign prod     = coef[tap_idx] * hist[tap_idx];
  assign prod_ext = {{(AW-CW-DW){prod[CW+DW-1]}}, prod};
  // Q5.6 -> Q6.12: sign-extend and scale by 2^6
  assign x_ext    = {{(AW-DW-6){in_data[DW-1]}}, in_data, 6'b0};

`ifdef IIR_INV_SAT_EN
  logic [AW-7:0] shifted;
  logic          ovf;
  assign shifted = acc[AW-1:6];
  // out of range when the bits above the DW-bit result are not a pure sign extension
  assign ovf  = ~((&shifted[AW-7:DW-1]) | ~(|shifted[AW-7:DW-1]));
  assign conv = ovf ? {shifted[AW-7], {(DW-1){~shifted[AW-7]}}} : shifted[DW-1:0];
`else
  assign conv = acc[DW+5:6];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (tap == TAP_END) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      started <= 1'b0;
      tap     <= '0;
      acc     <= '0;
      out_reg <= '0;
      for (int i = 0; i < 8; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      case (state)
        IDLE: begin
          // a write on the accept edge lands before the first multiply, so
          // the new sample already sees it
          if (coef_we && ({1'b0, coef_addr} < ORDER_L))
            coef[coef_addr] <= coef_data;
          if (accept) begin
            acc <= x_ext;
            tap <= 4'd1;
          end
        end
        MAC: begin
          if (tap != TAP_END) begin
            acc <= acc - prod_ext;
            tap <= tap + 4'd1;
          end else begin
            out_reg <= conv;
          end
        end
        OUT: begin
          // history keeps the emitted value, not the raw accumulator
          if (out_ready) begin
            hist[0] <= out_reg;
            for (int i = 1; i < 8; i++)
              if (i < ORDER) hist[i] <= hist[i-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
